// File: rtl/output_memory_ctrl_if.sv
// Bundle of the frame-sequencer control, input/output streams and RAM port.
// The slave modport is the controller's view; the master modport is the environment's.
interface output_memory_ctrl_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SIZE  = 64
);
  localparam int unsigned LOGSIZE = $clog2(SIZE);

  logic               start;
  logic [LOGSIZE:0]   frame_len;
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               mem_wr_en;
  logic [LOGSIZE-1:0] mem_wr_addr;
  logic [WIDTH-1:0]   mem_wr_data;
  logic [LOGSIZE-1:0] mem_rd_addr;
  logic [WIDTH-1:0]   mem_rd_data;
  logic               busy;
  logic               done;

  modport slave (
    input  start, frame_len, in_data, in_valid, out_ready, mem_rd_data,
    output in_ready, out_data, out_valid, out_last,
           mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr, busy, done
  );

  modport master (
    output start, frame_len, in_data, in_valid, out_ready, mem_rd_data,
    input  in_ready, out_data, out_valid, out_last,
           mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr, busy, done
  );
endinterface

// File: rtl/output_memory_ctrl.sv
// Output-buffer frame sequencer: fills a RAM from the MAC result stream, then
// drains the same frame in order to the output stream.
module output_memory_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SIZE  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  output_memory_ctrl_if.slave  bus
);
  localparam int unsigned LOGSIZE = $clog2(SIZE);
  localparam int unsigned LENW    = LOGSIZE + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  logic [LENW-1:0]    len;
  logic [LOGSIZE-1:0] wr_cnt;
  logic [LOGSIZE-1:0] rd_cnt;
  logic               done;

  logic [LOGSIZE-1:0] last_idx;
  logic               wr_hs;
  logic               rd_hs;
  logic               rd_last;

  // len is never zero outside IDLE, so len-1 always fits the address width
  assign last_idx = LOGSIZE'(len - LENW'(1));
  assign wr_hs    = (state == FILL)  && bus.in_valid;
  assign rd_hs    = (state == DRAIN) && bus.out_ready;
  assign rd_last  = (state == DRAIN) && (rd_cnt == last_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      len    <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && (bus.frame_len != '0)) begin
            len    <= (bus.frame_len > LENW'(SIZE)) ? LENW'(SIZE) : bus.frame_len;
            wr_cnt <= '0;
            state  <= FILL;
          end
        end
        FILL: begin
          if (wr_hs) begin
            // counters return to 0 at frame end so addresses read 0 while idle
            if (wr_cnt == last_idx) begin
              wr_cnt <= '0;
              rd_cnt <= '0;
              state  <= DRAIN;
            end else begin
              wr_cnt <= wr_cnt + LOGSIZE'(1);
            end
          end
        end
        DRAIN: begin
          if (rd_hs) begin
            if (rd_last) begin
              rd_cnt <= '0;
              done   <= 1'b1;
              state  <= IDLE;
            end else begin
              rd_cnt <= rd_cnt + LOGSIZE'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stream and RAM port outputs decode directly from the registered state/counters
  assign bus.in_ready    = (state == FILL);
  assign bus.out_valid   = (state == DRAIN);
  assign bus.out_last    = rd_last;
  assign bus.out_data    = bus.mem_rd_data;
  assign bus.mem_wr_en   = wr_hs;
  assign bus.mem_wr_addr = wr_cnt;
  assign bus.mem_wr_data = WIDTH'(bus.in_data);
  assign bus.mem_rd_addr = rd_cnt;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done;

endmodule

// File: tb/tb_output_memory_ctrl.sv
// Bench for output_memory_ctrl: a behavioural RAM sits beside the DUT and each frame
// is checked word-by-word against a queue of the values pushed in.
module tb_output_memory_ctrl;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned SIZE    = 64;
  localparam int unsigned LOGSIZE = $clog2(SIZE);

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  output_memory_ctrl_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

  output_memory_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External RAM: registered write, combinational read
  logic [WIDTH-1:0] ram [SIZE];
  always @(posedge clk) begin
    if (bus.mem_wr_en) ram[bus.mem_wr_addr] <= bus.mem_wr_data;
  end
  assign bus.mem_rd_data = ram[bus.mem_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, "_busy"},     32'(bus.busy),        0);
    check({tag, "_in_ready"}, 32'(bus.in_ready),    0);
    check({tag, "_out_valid"},32'(bus.out_valid),   0);
    check({tag, "_out_last"}, 32'(bus.out_last),    0);
    check({tag, "_wr_en"},    32'(bus.mem_wr_en),   0);
    check({tag, "_wr_addr"},  32'(bus.mem_wr_addr), 0);
    check({tag, "_rd_addr"},  32'(bus.mem_rd_addr), 0);
  endtask

  // Reset during a frame: start is also held high to show reset wins
  task automatic abort_with_reset();
    @(posedge clk); #1;
    reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.start = 1'b1;
    #1;
    @(posedge clk); #1;
    reset = 1'b0; bus.start = 1'b0;
    #1;
    idle_outputs("abort");
    check("abort_done", 32'(bus.done), 0);
    @(posedge clk); #1; #1;
    check("abort_done_next", 32'(bus.done), 0);
    check("abort_busy_next", 32'(bus.busy), 0);
  endtask

  // One frame: flen requested, pv_in/pv_out percent valid/ready, abort points (-1 none),
  // noise pulses start during the frame and in_valid during drain, base>=0 fixes data.
  task automatic run_frame(input int flen, input int pv_in, input int pv_out,
                           input int abort_fill, input int abort_drain,
                           input bit noise, input int base);
    int n;
    int w;
    int r;
    int cyc;
    logic [WIDTH-1:0] q[$];
    n = (flen > int'(SIZE)) ? int'(SIZE) : flen;
    for (int i = 0; i < n; i++)
      q.push_back((base >= 0) ? WIDTH'(base + i) : WIDTH'($urandom));

    @(posedge clk); #1;
    bus.start = 1'b1; bus.frame_len = (LOGSIZE+1)'(flen);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    check("start_idle_busy", 32'(bus.busy), 0);

    if (n == 0) begin
      @(posedge clk); #1; bus.start = 1'b0; #1;
      idle_outputs("len0");
      check("len0_done", 32'(bus.done), 0);
      @(posedge clk); #1; #1;
      check("len0_done_next", 32'(bus.done), 0);
      return;
    end

    w = 0; cyc = 0;
    while (w < n) begin
      if (w == abort_fill) begin
        abort_with_reset();
        return;
      end
      @(posedge clk); #1;
      bus.start    = noise && ($urandom_range(0, 3) == 0);
      bus.in_valid = (cyc > 500) || ($urandom_range(0, 99) < pv_in);
      bus.in_data  = q[w];
      #1;
      check("fill_in_ready",  32'(bus.in_ready),  1);
      check("fill_busy",      32'(bus.busy),      1);
      check("fill_out_valid", 32'(bus.out_valid), 0);
      check("fill_done",      32'(bus.done),      0);
      check("fill_wr_en",     32'(bus.mem_wr_en), 32'(bus.in_valid));
      if (bus.in_valid) begin
        check("fill_wr_addr", 32'(bus.mem_wr_addr), 32'(w));
        check("fill_wr_data", 32'(bus.mem_wr_data), 32'(q[w]));
        w++;
      end
      cyc++;
    end

    r = 0; cyc = 0;
    while (r < n) begin
      if (r == abort_drain) begin
        abort_with_reset();
        return;
      end
      @(posedge clk); #1;
      bus.start     = noise && ($urandom_range(0, 3) == 0);
      bus.in_valid  = noise && ($urandom_range(0, 1) == 0);
      bus.out_ready = (cyc > 500) || ($urandom_range(0, 99) < pv_out);
      #1;
      check("drain_out_valid", 32'(bus.out_valid),   1);
      check("drain_in_ready",  32'(bus.in_ready),    0);
      check("drain_wr_en",     32'(bus.mem_wr_en),   0);
      check("drain_rd_addr",   32'(bus.mem_rd_addr), 32'(r));
      check("drain_out_data",  32'(bus.out_data),    32'(q[r]));
      check("drain_out_last",  32'(bus.out_last),    32'(r == n - 1));
      check("drain_done",      32'(bus.done),        0);
      if (bus.out_ready) r++;
      cyc++;
    end

    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    check("end_done", 32'(bus.done), 1);
    idle_outputs("end");
    @(posedge clk); #1; #1;
    check("end_done_once", 32'(bus.done), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b1; bus.frame_len = (LOGSIZE+1)'(5);
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1; #1;
    idle_outputs("reset");
    check("reset_done", 32'(bus.done), 0);
    reset = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1; #1;
    idle_outputs("post_reset");

    run_frame(4,   100, 100, -1, -1, 1'b0, 10);
    run_frame(5,    50,  50, -1, -1, 1'b0, -1);
    run_frame(0,   100, 100, -1, -1, 1'b0, -1);
    run_frame(100,  70,  70, -1, -1, 1'b0, -1);
    run_frame(6,    60,  60, -1, -1, 1'b1, -1);
    run_frame(4,   100, 100,  2, -1, 1'b0, -1);
    run_frame(4,   100,  60, -1,  2, 1'b0, -1);
    run_frame(3,    80,  80, -1, -1, 1'b0, -1);
    run_frame(1,   100, 100, -1, -1, 1'b0, 16'hFFFF);
    run_frame(1,   100, 100, -1, -1, 1'b0, -1);
    for (int i = 0; i < 4; i++)
      run_frame(int'($urandom_range(1, 70)), 40 + i * 15, 40 + i * 15, -1, -1, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
